ext: RTL and testbench

- Immediate extender for the MIPS-style pipeline (decode stage).
- Widens the 16-bit instruction immediate to a 32-bit operand, zero- or sign-extended under control of EXTop.
- Primary output ExtImm is combinational and is consumed in the same cycle by the ALU operand mux and the branch/offset logic.
- An optional registered copy with a valid flag supports pipeline-register use.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ext.sv | 30 +++
 tb/tb_ext.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decode-stage constants and the immediate extension rule
package cpu_pkg;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Fill bit for the upper operand bits; any non-sign select zero-extends.
  function automatic logic ext_fill(input logic ext_op, input logic msb);
    return (ext_op == EXT_SIGN) & msb;
  endfunction

  // Full-width extension at the default widths, for stages that reuse the rule directly.
  function automatic logic [DATA_W-1:0] extend_imm(input logic ext_op, input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){ext_fill(ext_op, imm[IMM_W-1])}}, imm};
  endfunction

endpackage

// File: rtl/ext.sv
// rtl/ext.sv - immediate extender with optional registered copy
module ext
  import cpu_pkg::ext_fill;
#(
  parameter int IMM_W  = cpu_pkg::IMM_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EXTop,
  input  logic [IMM_W-1:0]  Imm,
  output logic [DATA_W-1:0] ExtImm,
  input  logic              en,
  output logic [DATA_W-1:0] ExtImm_q,
  output logic              ExtImm_vld
);

  assign ExtImm = {{(DATA_W-IMM_W){ext_fill(EXTop, Imm[IMM_W-1])}}, Imm};

  always_ff @(posedge clk) begin
    if (reset) begin
      ExtImm_q   <= '0;
      ExtImm_vld <= 1'b0;
    end else if (en) begin
      ExtImm_q   <= ExtImm;
      ExtImm_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext.sv
// tb/tb_ext.sv - randomized self-checking bench for ext
module tb_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXTop;
  logic [15:0] Imm;
  logic [31:0] ExtImm;
  logic        en;
  logic [31:0] ExtImm_q;
  logic        ExtImm_vld;

  int checks = 0;
  int failures = 0;

  logic [31:0] q_model;
  logic        vld_model;

  ext dut (
    .clk(clk), .reset(reset), .EXTop(EXTop), .Imm(Imm), .ExtImm(ExtImm),
    .en(en), .ExtImm_q(ExtImm_q), .ExtImm_vld(ExtImm_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference: value of the 16-bit field, plus 2^32 - 2^16 when sign-extending a negative field.
  function automatic logic [31:0] ref_ext(input logic op, input logic [15:0] imm);
    longint v;
    v = imm;
    if (op && imm >= 16'd32768) v = v + 64'd4294901760;
    return v[31:0];
  endfunction

  // Drive inputs mid-cycle, check the comb output, clock once, check the register.
  task automatic step(input logic r, input logic e, input logic op, input logic [15:0] imm,
                      input logic [31:0] exp_comb);
    @(negedge clk);
    reset = r; en = e; EXTop = op; Imm = imm;
    #1;
    check("ext_imm", ExtImm, exp_comb);
    check("ext_imm_ref", ExtImm, ref_ext(op, imm));
    @(posedge clk);
    if (r) begin
      q_model = 32'd0; vld_model = 1'b0;
    end else if (e) begin
      q_model = ref_ext(op, imm); vld_model = 1'b1;
    end
    #1;
    check("ext_imm_q", ExtImm_q, q_model);
    check("ext_imm_vld", {31'd0, ExtImm_vld}, {31'd0, vld_model});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; EXTop = 1'b0; Imm = 16'h0000;
    q_model = 32'd0; vld_model = 1'b0;

    step(1'b1, 1'b0, 1'b0, 16'h0000, 32'h00000000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 32'h00000000);

    step(1'b0, 1'b0, 1'b1, 16'h8000, 32'hFFFF8000);
    step(1'b0, 1'b0, 1'b0, 16'h8000, 32'h00008000);
    step(1'b0, 1'b0, 1'b1, 16'h7FFF, 32'h00007FFF);
    step(1'b0, 1'b0, 1'b0, 16'h7FFF, 32'h00007FFF);
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0000FFFF);
    step(1'b0, 1'b0, 1'b1, 16'h1234, 32'h00001234);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 32'h00000000);

    step(1'b0, 1'b1, 1'b1, 16'hABCD, 32'hFFFFABCD);
    check("q_after_load", ExtImm_q, 32'hFFFFABCD);
    step(1'b0, 1'b0, 1'b0, 16'h0001, 32'h00000001);
    check("q_hold", ExtImm_q, 32'hFFFFABCD);
    check("vld_hold", {31'd0, ExtImm_vld}, 32'd1);

    step(1'b1, 1'b1, 1'b1, 16'h9000, 32'hFFFF9000);
    check("q_reset_priority", ExtImm_q, 32'd0);
    check("vld_reset_priority", {31'd0, ExtImm_vld}, 32'd0);

    for (int i = 0; i < 10000; i++) begin
      logic r, e, op;
      logic [15:0] imm;
      r   = ($urandom_range(0, 63) == 0);
      e   = $urandom_range(0, 1);
      op  = $urandom_range(0, 1);
      imm = 16'($urandom);
      step(r, e, op, imm, ref_ext(op, imm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
